// File: rtl/adder_tree_loader.sv
// Packs a valid/ready operand stream into the 8 adder-tree lanes, zero-fills short batches and returns the tree sum.
// Latency: out_valid rises TREE_LATENCY+1 cycles after the closing beat; in_ready is low from close until the result handshake.
// Optional out_count port (operands in the batch) is enabled by defining ADDER_LOADER_COUNT_EN.
module adder_tree_loader #(
    parameter int ADDER_WIDTH  = 96,
    parameter int TREE_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDER_WIDTH-1:0]   in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [8*ADDER_WIDTH-1:0] lane_data,
    input  logic [ADDER_WIDTH:0]     tree_sum,
    output logic [ADDER_WIDTH:0]     out_sum,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef ADDER_LOADER_COUNT_EN
    ,
    output logic [3:0]               out_count
`endif
);

    localparam int CNT_W = (TREE_LATENCY < 1) ? 1 : $clog2(TREE_LATENCY + 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [2:0]             idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDER_WIDTH-1:0] lane_q [8];

    logic accept;
    logic close;

    assign accept = in_valid && in_ready;
    assign close  = accept && ((idx_q == 3'd7) || in_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = !rst;
                if (close) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= 3'd0;
            cnt_q     <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        idx_q <= idx_q + 3'd1;
                        // Lanes above the closing beat are zeroed so stale operands never reach the tree.
                        for (int k = 0; k < 8; k++) begin
                            if (k == int'(idx_q)) begin
                                lane_q[k] <= in_data;
                            end else if (close && (k > int'(idx_q))) begin
                                lane_q[k] <= '0;
                            end
                        end
                        if (close) begin
                            cnt_q <= CNT_W'(TREE_LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        out_sum   <= tree_sum;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        idx_q     <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDER_LOADER_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= 4'd0;
        end else if (close) begin
            out_count <= {1'b0, idx_q} + 4'd1;
        end
    end
`endif

    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign lane_data[g*ADDER_WIDTH +: ADDER_WIDTH] = lane_q[g];
    end

endmodule

// File: doc/adder_tree_loader.md
# adder_tree_loader

Stream-side front end for the 3-level, 8-operand adder tree. It accepts operands one per beat on a valid/ready stream and packs them into the tree's eight parallel lanes, zero-filling any lanes a short batch leaves empty. It waits out the tree's fixed register latency, then returns the captured sum on a valid/ready result port. It is the producer and consumer of the tree's parallel operand and sum interface.

## Interface
- ADDER_WIDTH, 96, operand width; must match the tree build.
- TREE_LATENCY, 2, clock edges from lane_data to a valid tree_sum (tree input register plus sum register).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  ADDER_WIDTH  operand.
- in_valid  in  1  operand beat valid.
- in_last  in  1  closes the batch early; qualified by in_valid && in_ready.
- in_ready  out  1  operand accepted when in_valid && in_ready.
- lane_data  out  8*ADDER_WIDTH  lane k at [k*ADDER_WIDTH +: ADDER_WIDTH]. Lane 0 drives isum0_0_0_0, lane 7 drives isum0_1_1_1, in binary order.
- tree_sum  in  ADDER_WIDTH+1  registered sum port of the tree.
- out_sum  out  ADDER_WIDTH+1  batch result.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.

## Operation
States: FILL, WAIT, HOLD.

- **FILL**
  - in_ready = 1.
  - Each accepted beat writes lane[idx], where idx is a 3-bit counter, then increments idx.
  - The batch closes on an accepted beat with idx == 7 or in_last == 1.
  - On close, lanes idx+1..7 are written with 0 on the same edge, the wait counter is loaded with TREE_LATENCY, and the state moves to WAIT.
  - A beat with in_last at idx 0 is a one-operand batch.
- **WAIT**
  - in_ready = 0.
  - The counter decrements each edge.
  - On the edge where the counter == 0: out_sum <= tree_sum, out_valid <= 1, state moves to HOLD.
- **HOLD**
  - in_ready = 0. out_sum and out_valid are stable until the handshake.
  - On out_valid && out_ready: out_valid <= 0, idx <= 0, state moves to FILL.
- lane_data is stable from the closing edge until the edge that captures out_sum.
- Lanes are not cleared when FILL is re-entered. Every lane is rewritten (data or zero) before the next close.
- Arithmetic: the block does no addition. out_sum is exactly tree_sum, i.e. the 8-operand sum truncated to ADDER_WIDTH+1 bits. Bits above that are lost without indication.
- in_valid bubbles in FILL are allowed; idx holds.
- in_last asserted without in_valid is ignored.

## Timing
- Reset values:
  - state FILL, idx 0, counter 0.
  - lane_data all 0, out_sum 0, out_valid 0.
  - in_ready 0 while rst is high; 1 from the first cycle after rst deasserts.
- Latency: closing beat accepted at edge E0. The tree input register captures at E1, the tree sum register at E2, and out_sum/out_valid update at E3. out_valid is therefore high TREE_LATENCY+1 cycles after the closing beat.
- Minimum batch period with out_ready held high: N beats + 3 + 1 cycles, for N = 1..8.
  - out_valid is high for exactly one cycle.
  - in_ready returns in the cycle after the result handshake.
- Reset mid-operation (FILL, WAIT or HOLD) discards the batch: no out_valid is produced and all registers take their reset values on that edge.
- A beat presented in the handshake cycle is not accepted, because in_ready = 0 in HOLD.

## Configuration
- ADDER_LOADER_COUNT_EN defined:
  - Adds port out_count (out, 4 bits): the number of real operands (1..8) in the batch.
  - out_count is captured at the close edge and presented alongside out_sum, with the same validity and stability as out_sum.
  - Reset value 0.
- ADDER_LOADER_COUNT_EN undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- After reset, 8 back-to-back beats 1..8 with out_ready = 1 -> out_sum = 36, out_valid high exactly 3 cycles after beat 8 for one cycle, and in_ready high again the next cycle.
- Beats 10, 20, 30 with in_last on the third beat -> lanes 3..7 = 0, out_sum = 60, out_count = 3 (macro defined).
- 8 beats of 2^96-1 -> out_sum = 2^97-8, the truncated value.
- out_ready held low 5 cycles after out_valid -> out_sum stable, in_ready = 0, in_valid beats ignored. Raising out_ready gives one handshake, and in_ready = 1 on the following cycle.
- rst pulsed for 1 cycle during WAIT -> out_valid never rises. A next batch 5, 5 with in_last gives out_sum = 10.
- Random 1-3 cycle in_valid bubbles between 8 beats of 100 -> out_sum = 800, same latency measured from the closing beat.
